// File: rtl/ccff_cfg_pkg.sv
// Shared types and sizing helpers for the ccff chain loader.
// Holds the FSM state encoding, the word-count arithmetic and the parity fold step.
package ccff_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } ccff_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 32'd1) / den;
  endfunction

  // Number of bitstream words needed to cover the whole chain.
  function automatic int unsigned num_words(input int unsigned chain_len, input int unsigned word_w);
    return ceil_div(chain_len, word_w);
  endfunction

  function automatic logic parity_update(input logic acc, input logic en, input logic bit_v);
    return acc ^ (en & bit_v);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake plus the serial chain pins of the configuration fabric.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
) ();

  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;
  logic              ccff_head;
  logic              prog_clk_en;
  logic              ccff_tail;

  modport master (
    output word_valid, word_data, ccff_tail,
    input  word_ready, ccff_head, prog_clk_en
  );

  modport slave (
    input  word_valid, word_data, ccff_tail,
    output word_ready, ccff_head, prog_clk_en
  );

endinterface

// File: rtl/ccff_piso.sv
// Parallel-in serial-out word shifter, LSB first, with a per-load bit count.
// empty rises while the last valid bit is being presented, so a refill lands without a gap.
module ccff_piso #(
  parameter  int WORD_W = 8,
  localparam int CNT_W  = $clog2(WORD_W + 32'sd1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_bits,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              empty
);

  logic [WORD_W-1:0] data_r;
  logic [CNT_W-1:0]  cnt_r;

  // Shift register and remaining-bit counter; a load takes priority over a shift.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data_r <= {WORD_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else if (load) begin
      data_r <= load_data;
      cnt_r  <= load_bits;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      data_r <= data_r >> 1;
      cnt_r  <= cnt_r - CNT_W'(1);
    end
  end

  assign bit_valid = (cnt_r != {CNT_W{1'b0}});
  assign bit_out   = data_r[0];
  assign empty     = (cnt_r <= CNT_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams a word-wide bitstream into a serial configuration flop chain, gating the
// fabric clock so the chain advances exactly CHAIN_LEN times, and folds the tail parity.
module ccff_chain_loader
  import ccff_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8
) (
  input  logic               prog_clk,
  input  logic               pReset,
  input  logic               start,
  ccff_chain_loader_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               tail_parity
);

  localparam int NUM_WORDS  = int'(num_words(CHAIN_LEN, WORD_W));
  localparam int LAST_REM   = CHAIN_LEN % WORD_W;
  localparam int LAST_BITS  = (LAST_REM == 32'sd0) ? WORD_W : LAST_REM;
  localparam int BIT_CNT_W  = $clog2(CHAIN_LEN + 32'sd1);
  localparam int WORD_CNT_W = $clog2(NUM_WORDS + 32'sd1);
  localparam int PISO_CNT_W = $clog2(WORD_W + 32'sd1);

  ccff_state_e           state_r;
  ccff_state_e           next_state_s;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  logic [WORD_CNT_W-1:0] word_cnt_r;
  logic                  parity_acc_r;
  logic                  head_r;
  logic                  en_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  tail_parity_r;

  logic                  ready_s;
  logic                  accept_s;
  logic                  shift_s;
  logic                  clr_s;
  logic                  finish_s;
  logic [PISO_CNT_W-1:0] load_bits_s;
  logic                  piso_valid_s;
  logic                  piso_bit_s;
  logic                  piso_empty_s;

  ccff_piso #(.WORD_W(WORD_W)) u_piso (
    .clk       (prog_clk),
    .rst       (pReset),
    .clr       (clr_s),
    .load      (accept_s),
    .load_data (bus.word_data),
    .load_bits (load_bits_s),
    .bit_valid (piso_valid_s),
    .bit_out   (piso_bit_s),
    .empty     (piso_empty_s)
  );

  // Next-state decode and the per-cycle handshake/shift strobes.
  always_comb begin
    next_state_s = state_r;
    ready_s      = 1'b0;
    accept_s     = 1'b0;
    shift_s      = 1'b0;
    clr_s        = 1'b0;
    finish_s     = 1'b0;
    load_bits_s  = PISO_CNT_W'(WORD_W);
    // The final word only carries the bits left over after the full words.
    if (word_cnt_r == WORD_CNT_W'(NUM_WORDS - 32'sd1)) begin
      load_bits_s = PISO_CNT_W'(LAST_BITS);
    end else begin
      load_bits_s = PISO_CNT_W'(WORD_W);
    end
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_LOAD;
          clr_s        = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        ready_s  = piso_empty_s && (word_cnt_r < WORD_CNT_W'(NUM_WORDS));
        accept_s = ready_s && bus.word_valid;
        shift_s  = piso_valid_s;
        if (bit_cnt_r == BIT_CNT_W'(CHAIN_LEN)) begin
          next_state_s = ST_FINISH;
          finish_s     = 1'b1;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_FINISH: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters, serial output register and parity accumulator.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= {BIT_CNT_W{1'b0}};
      word_cnt_r    <= {WORD_CNT_W{1'b0}};
      parity_acc_r  <= 1'b0;
      head_r        <= 1'b0;
      en_r          <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      tail_parity_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_LOAD);
      done_r  <= finish_s;
      en_r    <= shift_s;
      if (shift_s) begin
        head_r <= piso_bit_s;
      end
      // The last enabled cycle's tail bit is folded in on the same edge that publishes.
      if (finish_s) begin
        tail_parity_r <= parity_update(parity_acc_r, en_r, bus.ccff_tail);
      end
      if (clr_s) begin
        bit_cnt_r    <= {BIT_CNT_W{1'b0}};
        word_cnt_r   <= {WORD_CNT_W{1'b0}};
        parity_acc_r <= 1'b0;
      end else begin
        if (shift_s) begin
          bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
        end
        if (accept_s) begin
          word_cnt_r <= word_cnt_r + WORD_CNT_W'(1);
        end
        parity_acc_r <= parity_update(parity_acc_r, en_r, bus.ccff_tail);
      end
    end
  end

  assign bus.word_ready  = ready_s;
  assign bus.ccff_head   = head_r;
  assign bus.prog_clk_en = en_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign tail_parity     = tail_parity_r;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Drives a 48-flop and a 44-flop loader from one word stream, each feeding a behavioural
// chain, and checks every enabled bit, tail stream, timing and parity against a bitstream model.
module tb_ccff_chain_loader;

  localparam int LEN_A = 48;
  localparam int LEN_B = 44;
  localparam int W     = 8;
  localparam int NW    = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       word_valid;
  logic [7:0] word_data;
  logic       busy_a, done_a, par_a, busy_b, done_b, par_b;

  ccff_chain_loader_if #(.WORD_W(W)) bus_a ();
  ccff_chain_loader_if #(.WORD_W(W)) bus_b ();

  ccff_chain_loader #(.CHAIN_LEN(LEN_A), .WORD_W(W)) dut_a (
    .prog_clk(clk), .pReset(rst), .start(start), .bus(bus_a),
    .busy(busy_a), .done(done_a), .tail_parity(par_a));
  ccff_chain_loader #(.CHAIN_LEN(LEN_B), .WORD_W(W)) dut_b (
    .prog_clk(clk), .pReset(rst), .start(start), .bus(bus_b),
    .busy(busy_b), .done(done_b), .tail_parity(par_b));

  always #5 clk = ~clk;

  // Behavioural configuration chains: head enters at the far end, tail is flop 0.
  logic [LEN_A-1:0] chain_a;
  logic [LEN_B-1:0] chain_b;
  logic             pre_req;
  logic [LEN_A-1:0] pre_a;
  logic [LEN_B-1:0] pre_b;

  always @(posedge clk) begin
    if (pre_req) chain_a <= pre_a;
    else if (bus_a.prog_clk_en) chain_a <= {bus_a.ccff_head, chain_a[LEN_A-1:1]};
  end
  always @(posedge clk) begin
    if (pre_req) chain_b <= pre_b;
    else if (bus_b.prog_clk_en) chain_b <= {bus_b.ccff_head, chain_b[LEN_B-1:1]};
  end

  assign bus_a.word_valid = word_valid;
  assign bus_b.word_valid = word_valid;
  assign bus_a.word_data  = word_data;
  assign bus_b.word_data  = word_data;
  assign bus_a.ccff_tail  = chain_a[0];
  assign bus_b.ccff_tail  = chain_b[0];

  wire [1:0] en_w    = {bus_b.prog_clk_en, bus_a.prog_clk_en};
  wire [1:0] head_w  = {bus_b.ccff_head, bus_a.ccff_head};
  wire [1:0] tail_w  = {bus_b.ccff_tail, bus_a.ccff_tail};
  wire [1:0] ready_w = {bus_b.word_ready, bus_a.word_ready};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: expected bitstream, expected tail stream (previous chain contents) and parity.
  logic [47:0] exp_bits [2];
  logic [47:0] exp_tail [2];
  int          exp_n    [2];
  logic        exp_par  [2];
  logic [47:0] mc       [2];
  int          load_id;

  // Observed per-load statistics, owned by the compare process.
  int          seen_id = -1;
  int          cyc_n = 0;
  int          en_cnt   [2];
  int          acc_cnt  [2];
  int          first_en [2];
  int          last_en  [2];
  logic [47:0] hlog     [2];
  logic [47:0] tlog     [2];
  logic        prev_head[2];
  logic        rst_q;

  always @(posedge clk) rst_q <= rst;

  // Per-cycle compare against the bitstream model.
  always @(negedge clk) begin
    cyc_n++;
    if (load_id != seen_id) begin
      seen_id = load_id;
      for (int d = 0; d < 2; d++) begin
        en_cnt[d] = 0; acc_cnt[d] = 0; first_en[d] = 0; last_en[d] = 0;
        hlog[d] = 48'h0; tlog[d] = 48'h0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (ready_w[d]) check($sformatf("ready_limit_%0d", d), 64'(acc_cnt[d] < NW), 64'd1);
      if (word_valid && ready_w[d]) acc_cnt[d]++;
      if (en_w[d]) begin
        if (en_cnt[d] < exp_n[d]) begin
          check($sformatf("head_%0d_bit%0d", d, en_cnt[d]), 64'(head_w[d]), 64'(exp_bits[d][en_cnt[d]]));
          check($sformatf("tail_%0d_bit%0d", d, en_cnt[d]), 64'(tail_w[d]), 64'(exp_tail[d][en_cnt[d]]));
          hlog[d][en_cnt[d]] = head_w[d];
          tlog[d][en_cnt[d]] = tail_w[d];
        end else begin
          check($sformatf("en_overrun_%0d", d), 64'(en_cnt[d] + 1), 64'(exp_n[d]));
        end
        if (en_cnt[d] == 0) first_en[d] = cyc_n;
        last_en[d] = cyc_n;
        en_cnt[d]++;
      end else if (!rst_q) begin
        check($sformatf("head_hold_%0d", d), 64'(head_w[d]), 64'(prev_head[d]));
      end
      prev_head[d] = head_w[d];
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_head_a"},  64'(bus_a.ccff_head),   64'd0);
    check({tag, "_en_a"},    64'(bus_a.prog_clk_en), 64'd0);
    check({tag, "_ready_a"}, 64'(bus_a.word_ready),  64'd0);
    check({tag, "_busy_a"},  64'(busy_a), 64'd0);
    check({tag, "_done_a"},  64'(done_a), 64'd0);
    check({tag, "_par_a"},   64'(par_a),  64'd0);
    check({tag, "_en_b"},    64'(bus_b.prog_clk_en), 64'd0);
    check({tag, "_busy_b"},  64'(busy_b), 64'd0);
    check({tag, "_par_b"},   64'(par_b),  64'd0);
  endtask

  task automatic preload(input logic [47:0] a, input logic [47:0] b);
    pre_a = a;
    pre_b = b[LEN_B-1:0];
    pre_req = 1'b1;
    @(posedge clk); #1;
    pre_req = 1'b0;
    mc[0] = a;
    mc[1] = {4'h0, b[LEN_B-1:0]};
  endtask

  task automatic run_load(input logic [47:0] ws, input int stall_after, input bit start_mid,
                          input int abort_at, output int dca);
    int idx, phase, scnt, bits, dcb, st, len;
    logic p, acc;
    logic [47:0] nc;
    idx = 0; phase = 0; scnt = 0; bits = 0; dca = 0; dcb = 0;
    st = (stall_after > 0) ? 5 : 0;
    for (int d = 0; d < 2; d++) begin
      len = (d == 0) ? LEN_A : LEN_B;
      p = 1'b0;
      nc = 48'h0;
      for (int i = 0; i < 48; i++) begin
        exp_bits[d][i] = (i < len) ? ws[i] : 1'b0;
        exp_tail[d][i] = mc[d][i];
        if (i < len) begin
          p = p ^ mc[d][i];
          nc[i] = ws[i];
        end
      end
      exp_n[d] = len;
      exp_par[d] = p;
      mc[d] = nc;
    end
    load_id++;
    start = 1'b1;
    word_valid = 1'b1;
    word_data = ws[7:0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      acc = word_valid && bus_a.word_ready;
      if (phase == 1 && bus_a.word_ready) begin phase = 2; scnt = 0; end
      @(posedge clk); #1;
      if (start_mid) start = (cyc == 10);
      if (bus_a.prog_clk_en) bits++;
      if (done_b && dcb == 0) dcb = cyc;
      if (done_a) begin dca = cyc; break; end
      if (abort_at > 0 && bits == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("abort");
        rst = 1'b0;
        word_valid = 1'b0;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_en_total_a", 64'(en_cnt[0]), 64'(abort_at));
        check("abort_en_total_b", 64'(en_cnt[1]), 64'(abort_at));
        return;
      end
      if (acc) begin
        idx++;
        if (idx == NW) word_valid = 1'b0;
        else begin
          word_data = ws[8*idx +: 8];
          if (idx == stall_after) begin word_valid = 1'b0; phase = 1; end
        end
      end
      if (phase == 2) begin
        scnt++;
        if (scnt == 5) begin phase = 0; word_valid = 1'b1; end
      end
    end
    check("done_cycle_a", 64'(dca), 64'(LEN_A + 2 + st));
    check("done_cycle_b", 64'(dcb), 64'(LEN_B + 2 + st));
    check("en_total_a", 64'(en_cnt[0]), 64'(LEN_A));
    check("en_total_b", 64'(en_cnt[1]), 64'(LEN_B));
    check("en_span_a", 64'(last_en[0] - first_en[0] + 1), 64'(LEN_A + st));
    check("en_span_b", 64'(last_en[1] - first_en[1] + 1), 64'(LEN_B + st));
    check("words_accepted_a", 64'(acc_cnt[0]), 64'(NW));
    check("words_accepted_b", 64'(acc_cnt[1]), 64'(NW));
    check("tail_parity_a", 64'(par_a), 64'(exp_par[0]));
    check("tail_parity_b", 64'(par_b), 64'(exp_par[1]));
    @(posedge clk); #1;
    check("done_pulse_a", 64'(done_a), 64'd0);
    check("idle_after_a", 64'(busy_a), 64'd0);
  endtask

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = 8'h00;
    pre_req = 1'b0; pre_a = '0; pre_b = '0; load_id = 0;
    for (int d = 0; d < 2; d++) begin
      exp_n[d] = 0; exp_bits[d] = 48'h0; exp_tail[d] = 48'h0; exp_par[d] = 1'b0; mc[d] = 48'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Odd-parity chain contents; a stray start mid-load must be ignored.
    preload(48'h7, 48'h7);
    run_load(48'h060504030201, 0, 1'b1, 0, dc);
    check("first_done_literal", 64'(dc), 64'd50);
    check("first_word_bits", 64'(hlog[0][7:0]), 64'h01);
    check("odd_parity_literal", 64'(par_a), 64'd1);

    // Stall after word 2; tail stream must replay the previous bitstream.
    run_load(48'hA53CF00F9966, 2, 1'b0, 0, dc);
    check("stall_done_literal", 64'(dc), 64'd55);
    check("replay_tail_a", 64'(tlog[0]), 64'h060504030201);
    check("replay_tail_b", 64'(tlog[1][43:0]), 64'h60504030201);

    // Final word all ones: the 44-flop loader emits only its low nibble.
    run_load(48'hFF1122334455, 0, 1'b0, 0, dc);
    check("b_last_nibble", 64'(hlog[1][43:40]), 64'hF);
    check("b_en_literal", 64'(en_cnt[1]), 64'd44);

    // Abort at bit 20, then a clean load from a known chain state.
    run_load(48'h0F0E0D0C0B0A, 0, 1'b0, 20, dc);
    preload(48'h0, 48'h0);
    run_load(48'h123456789ABC, 0, 1'b0, 0, dc);
    check("after_abort_head_a", 64'(hlog[0]), 64'h123456789ABC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 48, SHALL give the number of configuration flops in the downstream ccff chain.
REQ-002 Parameter WORD_W, default 8, SHALL give the bitstream word width.
REQ-003 prog_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 pReset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  input  1  SHALL request one full chain load; sampled only in IDLE.
REQ-006 word_valid  input  1  SHALL mark word_data valid.
REQ-007 word_data  input  WORD_W  SHALL carry bitstream word n, holding bits n*WORD_W .. n*WORD_W+WORD_W-1, with LSB = lowest index.
REQ-008 word_ready  output  1  SHALL indicate the loader accepts a word this cycle.
REQ-009 ccff_head  output  1  SHALL drive the chain serial input, registered.
REQ-010 prog_clk_en  output  1  SHALL enable the fabric clock gate; the chain shifts only on cycles where it is 1.
REQ-011 ccff_tail  input  1  SHALL carry the chain serial output.
REQ-012 busy  output  1  SHALL be high in LOAD.
REQ-013 done  output  1  SHALL be a one-cycle pulse when the load completes.
REQ-014 tail_parity  output  1  SHALL hold the XOR of the ccff_tail values sampled on enabled cycles of the last load.

Function
REQ-015 States SHALL be IDLE, LOAD and FINISH; no other states.
REQ-016 IDLE -> LOAD when start=1; the bit counter, word counter, shifter and parity accumulator clear on the same edge.
REQ-017 Bit k=0 (the flop nearest ccff_tail) SHALL be emitted first; bits follow in ascending k.
REQ-018 word_ready SHALL be 1 only in LOAD, with the shifter empty and words_accepted < ceil(CHAIN_LEN/WORD_W); it has no combinational dependence on word_valid.
REQ-019 A word is accepted iff word_valid & word_ready; word_data loads into the shifter on that edge.
REQ-020 ccff_head is registered, so each bit SHALL appear one cycle after its shifter slot, with prog_clk_en=1 in the same cycle as that bit.
REQ-021 prog_clk_en SHALL be 0 on any cycle without a new valid bit (bubble, IDLE, FINISH); ccff_head then holds its last value.
REQ-022 Back-to-back words SHALL stream with zero bubbles: ready reasserts in the cycle the last bit of the current word shifts out.
REQ-023 For the final word, only the low CHAIN_LEN mod WORD_W bits SHALL be shifted (all WORD_W bits if the remainder is 0); the upper bits are discarded.
REQ-024 The total count of prog_clk_en=1 cycles per load SHALL equal CHAIN_LEN exactly; the bit counter width is clog2(CHAIN_LEN+1).
REQ-025 On every prog_clk_en=1 cycle the parity accumulator SHALL XOR in ccff_tail.
REQ-026 LOAD -> FINISH on the cycle after the CHAIN_LEN-th enabled cycle; FINISH SHALL pulse done=1, update tail_parity, and return to IDLE the next cycle.
REQ-027 start asserted outside IDLE SHALL be ignored; start held in IDLE after done SHALL begin a new load.
REQ-028 A stalled word_valid SHALL hold the loader in LOAD indefinitely, with prog_clk_en=0 throughout.

Reset
REQ-029 pReset=1 SHALL force IDLE and, on the following edge, ccff_head=0, prog_clk_en=0, word_ready=0, busy=0, done=0, tail_parity=0, and clear all counters.
REQ-030 pReset during LOAD SHALL abort without further enabled cycles; partial chain contents are not restored.

Structure
REQ-031 The state enum and the function computing ceil(CHAIN_LEN/WORD_W) SHALL reside in the shared package ccff_cfg_pkg.
REQ-032 The block SHALL contain one sub-module, ccff_piso (a WORD_W parallel-in serial-out shifter with an empty flag); the FSM and counters stay in the top.

Verification
REQ-033 Defaults; start; 6 words 0x01..0x06 with word_valid held 1 -> exactly 48 prog_clk_en cycles, no bubbles; first ccff_head bit=1, bits 1..7=0; done at cycle 50 after start.
REQ-034 CHAIN_LEN=44, last word 0xFF -> 44 enabled cycles; only the low 4 bits of the last word are emitted; word_ready deasserts after 6 accepts.
REQ-035 word_valid dropped for 5 cycles after word 2 -> prog_clk_en=0 for those cycles, ccff_head stable, total still 48.
REQ-036 pReset pulsed at bit 20 -> next cycle all outputs 0 and state IDLE; a subsequent full load completes correctly.
REQ-037 Chain model preloaded with 48 bits of odd parity -> tail_parity=1 at done; a second start during LOAD is ignored.
REQ-038 Load 48 bits, then load again with a chain model -> the bits shifted out of ccff_tail during the second load equal the first bitstream, in order.
